// File: rtl/eth_arb_defs_pkg.sv
// Shared definitions for the Ethernet TX frame arbiter: state encodings,
// header/payload widths and the skid-stage beat record.
package eth_arb_defs;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } arbState_t;

   localparam int MAC_W     = 48;
   localparam int TYPE_W    = 16;
   localparam int ETH_HDR_W = 2 * MAC_W + TYPE_W;
   localparam int DATA_W    = 64;
   localparam int KEEP_W    = 8;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
      logic              user;
   } beat_t;

endpackage

// File: rtl/eth_tx_arb_64_rr_prio_enc.sv
// N-wide round-robin priority encoder: the search begins one past 'last'
// and wraps, so last = N-1 degenerates to a lowest-index-first encoder.
module rr_prio_enc #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic          valid_o,
   output logic [IW-1:0] index_o
);

   logic [IW-1:0] startIdx;
   logic [IW:0]   pos;

   always_comb begin
      valid_o  = 1'b0;
      index_o  = '0;
      pos      = '0;
      startIdx = (last_i >= IW'(N - 1)) ? '0 : last_i + IW'(1);
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, startIdx} + (IW + 1)'(k);
         if (pos >= (IW + 1)'(N)) begin
            pos = pos - (IW + 1)'(N);
         end
         if (!valid_o && req_i[pos[IW-1:0]]) begin
            valid_o = 1'b1;
            index_o = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/eth_tx_arb_64.sv
// Frame-atomic arbiter sharing one eth_axis_tx_64 path among S_COUNT sources:
// registered header forwarding plus a two-entry payload skid stage.
module eth_tx_arb_64
   import eth_arb_defs::*;
#(
   parameter int S_COUNT = 4,
   parameter int ARB_RR  = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [S_COUNT-1:0]           input_eth_hdr_valid,
   output logic [S_COUNT-1:0]           input_eth_hdr_ready,
   input  logic [S_COUNT*48-1:0]        input_eth_dest_mac,
   input  logic [S_COUNT*48-1:0]        input_eth_src_mac,
   input  logic [S_COUNT*16-1:0]        input_eth_type,
   input  logic [S_COUNT*64-1:0]        input_eth_payload_tdata,
   input  logic [S_COUNT*8-1:0]         input_eth_payload_tkeep,
   input  logic [S_COUNT-1:0]           input_eth_payload_tvalid,
   output logic [S_COUNT-1:0]           input_eth_payload_tready,
   input  logic [S_COUNT-1:0]           input_eth_payload_tlast,
   input  logic [S_COUNT-1:0]           input_eth_payload_tuser,
   output logic                         output_eth_hdr_valid,
   input  logic                         output_eth_hdr_ready,
   output logic [47:0]                  output_eth_dest_mac,
   output logic [47:0]                  output_eth_src_mac,
   output logic [15:0]                  output_eth_type,
   output logic [63:0]                  output_eth_payload_tdata,
   output logic [7:0]                   output_eth_payload_tkeep,
   output logic                         output_eth_payload_tvalid,
   input  logic                         output_eth_payload_tready,
   output logic                         output_eth_payload_tlast,
   output logic                         output_eth_payload_tuser,
   output logic                         grant_valid,
   output logic [$clog2(S_COUNT)-1:0]   grant_index
);

   localparam int IW = $clog2(S_COUNT);

   arbState_t              state_q, state_d;
   logic [IW-1:0]          last_q, last_d;
   logic [IW-1:0]          grantIdx_q, grantIdx_d;
   logic                   grantValid_q, grantValid_d;
   logic                   hdrValid_q, hdrValid_d;
   logic [ETH_HDR_W-1:0]   hdr_q, hdr_d;
   logic                   lastIn_q, lastIn_d;
   logic                   lastOut_q, lastOut_d;
   logic [1:0]             skidCount_q, skidCount_d;
   beat_t                  skid0_q, skid0_d;
   beat_t                  skid1_q, skid1_d;

   logic [IW-1:0]          encLast;
   logic                   winValid;
   logic [IW-1:0]          winIdx;
   logic [ETH_HDR_W-1:0]   winHdr;
   beat_t                  selBeat;
   logic                   selValid;
   logic                   hdrAccept;
   logic                   inReady;
   logic                   push;
   logic                   pop;
   logic                   tlastOut;
   logic                   frameDone;

   // Fixed priority reuses the round-robin encoder pinned to start at index 0.
   assign encLast = (ARB_RR != 0) ? last_q : IW'(S_COUNT - 1);

   rr_prio_enc #(
      .N  (S_COUNT),
      .IW (IW)
   ) uEnc (
      .req_i   (input_eth_hdr_valid),
      .last_i  (encLast),
      .valid_o (winValid),
      .index_o (winIdx)
   );

   assign winHdr = {input_eth_dest_mac[winIdx*MAC_W +: MAC_W],
                    input_eth_src_mac[winIdx*MAC_W +: MAC_W],
                    input_eth_type[winIdx*TYPE_W +: TYPE_W]};

   assign selBeat.data = input_eth_payload_tdata[grantIdx_q*DATA_W +: DATA_W];
   assign selBeat.keep = input_eth_payload_tkeep[grantIdx_q*KEEP_W +: KEEP_W];
   assign selBeat.last = input_eth_payload_tlast[grantIdx_q];
   assign selBeat.user = input_eth_payload_tuser[grantIdx_q];
   assign selValid     = input_eth_payload_tvalid[grantIdx_q];

   // Input ready is built from registers only so it never sees output tready.
   assign hdrAccept = (state_q == ST_IDLE) && winValid;
   assign inReady   = (state_q == ST_ACTIVE) && !lastIn_q && (skidCount_q != 2'd2);
   assign push      = inReady && selValid;
   assign pop       = (skidCount_q != 2'd0) && output_eth_payload_tready;
   assign tlastOut  = pop && skid0_q.last;
   assign frameDone = (state_q == ST_ACTIVE) && (lastOut_q || tlastOut) &&
                      (!hdrValid_q || output_eth_hdr_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (winValid)  state_d = ST_ACTIVE;
         ST_ACTIVE: if (frameDone) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      input_eth_hdr_ready      = '0;
      input_eth_payload_tready = '0;
      if (hdrAccept) begin
         input_eth_hdr_ready = S_COUNT'(1) << winIdx;
      end
      if (inReady) begin
         input_eth_payload_tready = S_COUNT'(1) << grantIdx_q;
      end
   end

   always_comb begin
      last_d       = last_q;
      grantIdx_d   = grantIdx_q;
      grantValid_d = grantValid_q;
      hdrValid_d   = hdrValid_q;
      hdr_d        = hdr_q;
      lastIn_d     = lastIn_q;
      lastOut_d    = lastOut_q;
      skidCount_d  = skidCount_q;
      skid0_d      = skid0_q;
      skid1_d      = skid1_q;

      if (hdrAccept) begin
         hdrValid_d   = 1'b1;
         hdr_d        = winHdr;
         grantValid_d = 1'b1;
         grantIdx_d   = winIdx;
         last_d       = winIdx;
         lastIn_d     = 1'b0;
         lastOut_d    = 1'b0;
      end else if (hdrValid_q && output_eth_hdr_ready) begin
         hdrValid_d = 1'b0;
      end

      if (push && selBeat.last) lastIn_d = 1'b1;
      if (tlastOut) lastOut_d = 1'b1;
      if (frameDone) begin
         grantValid_d = 1'b0;
         lastIn_d     = 1'b0;
         lastOut_d    = 1'b0;
      end

      // Entry 0 is always the head; entry 1 only fills while the head stalls.
      case ({push, pop})
         2'b10: begin
            if (skidCount_q == 2'd0) skid0_d = selBeat;
            else                     skid1_d = selBeat;
            skidCount_d = skidCount_q + 2'd1;
         end
         2'b01: begin
            skid0_d     = skid1_q;
            skidCount_d = skidCount_q - 2'd1;
         end
         2'b11: begin
            if (skidCount_q == 2'd1) begin
               skid0_d = selBeat;
            end else begin
               skid0_d = skid1_q;
               skid1_d = selBeat;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q       <= IW'(S_COUNT - 1);
         grantIdx_q   <= '0;
         grantValid_q <= 1'b0;
         hdrValid_q   <= 1'b0;
         hdr_q        <= '0;
         lastIn_q     <= 1'b0;
         lastOut_q    <= 1'b0;
         skidCount_q  <= 2'd0;
         skid0_q      <= '0;
         skid1_q      <= '0;
      end else begin
         last_q       <= last_d;
         grantIdx_q   <= grantIdx_d;
         grantValid_q <= grantValid_d;
         hdrValid_q   <= hdrValid_d;
         hdr_q        <= hdr_d;
         lastIn_q     <= lastIn_d;
         lastOut_q    <= lastOut_d;
         skidCount_q  <= skidCount_d;
         skid0_q      <= skid0_d;
         skid1_q      <= skid1_d;
      end
   end

   assign output_eth_hdr_valid      = hdrValid_q;
   assign output_eth_dest_mac       = hdr_q[ETH_HDR_W-1 -: MAC_W];
   assign output_eth_src_mac        = hdr_q[TYPE_W +: MAC_W];
   assign output_eth_type           = hdr_q[TYPE_W-1:0];
   assign output_eth_payload_tdata  = skid0_q.data;
   assign output_eth_payload_tkeep  = skid0_q.keep;
   assign output_eth_payload_tvalid = (skidCount_q != 2'd0);
   assign output_eth_payload_tlast  = skid0_q.last;
   assign output_eth_payload_tuser  = skid0_q.user;
   assign grant_valid               = grantValid_q;
   assign grant_index               = grantIdx_q;

endmodule

// File: tb/tb_eth_tx_arb_64.sv
// Self-checking bench for eth_tx_arb_64: source models feed a scoreboard of
// expected headers/beats, plus an arbitration vector table and corner sequences.
module tb_eth_tx_arb_64;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } tbBeat_t;

   typedef struct {
      logic [3:0] reqMask;
      int         expGrant;
   } arbVec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   hdrValid, hdrReady;
   logic [191:0] destMac, srcMac;
   logic [63:0]  ethType;
   logic [255:0] pData;
   logic [31:0]  pKeep;
   logic [3:0]   pValid, pReady, pLast, pUser;
   logic         oHdrValid, oHdrReady;
   logic [47:0]  oDest, oSrc;
   logic [15:0]  oType;
   logic [63:0]  oData;
   logic [7:0]   oKeep;
   logic         oValid, oReady, oLast, oUser;
   logic         grantValid;
   logic [1:0]   grantIndex;

   logic [3:0]   bHdrValid, bHdrReady, bPValid, bPReady;
   logic         bOHdrValid, bOValid, bOLast, bOUser, bGrantValid;
   logic [47:0]  bODest, bOSrc;
   logic [15:0]  bOType;
   logic [63:0]  bOData;
   logic [7:0]   bOKeep;
   logic [1:0]   bGrantIndex;

   int tests = 0;
   int failures = 0;
   int pend[4], beats[4], beatIdx[4], frameNo[4];
   bit hdrSent[4];
   bit randReady, hdrReadyCtl, expectHdrValid, expectOutValid;
   int outBeats, framesOut;
   tbBeat_t expBeatQ[$];
   logic [111:0] expHdrQ[$];
   int grantLog[$];
   arbVec_t vecs[12];

   always #5 clk = ~clk;

   eth_tx_arb_64 #(.S_COUNT(4), .ARB_RR(1)) dut (
      .clk(clk), .rst(rst),
      .input_eth_hdr_valid(hdrValid), .input_eth_hdr_ready(hdrReady),
      .input_eth_dest_mac(destMac), .input_eth_src_mac(srcMac), .input_eth_type(ethType),
      .input_eth_payload_tdata(pData), .input_eth_payload_tkeep(pKeep),
      .input_eth_payload_tvalid(pValid), .input_eth_payload_tready(pReady),
      .input_eth_payload_tlast(pLast), .input_eth_payload_tuser(pUser),
      .output_eth_hdr_valid(oHdrValid), .output_eth_hdr_ready(oHdrReady),
      .output_eth_dest_mac(oDest), .output_eth_src_mac(oSrc), .output_eth_type(oType),
      .output_eth_payload_tdata(oData), .output_eth_payload_tkeep(oKeep),
      .output_eth_payload_tvalid(oValid), .output_eth_payload_tready(oReady),
      .output_eth_payload_tlast(oLast), .output_eth_payload_tuser(oUser),
      .grant_valid(grantValid), .grant_index(grantIndex)
   );

   eth_tx_arb_64 #(.S_COUNT(4), .ARB_RR(0)) dutFixed (
      .clk(clk), .rst(rst),
      .input_eth_hdr_valid(bHdrValid), .input_eth_hdr_ready(bHdrReady),
      .input_eth_dest_mac('0), .input_eth_src_mac('0), .input_eth_type('0),
      .input_eth_payload_tdata('0), .input_eth_payload_tkeep('1),
      .input_eth_payload_tvalid(bPValid), .input_eth_payload_tready(bPReady),
      .input_eth_payload_tlast(4'hF), .input_eth_payload_tuser('0),
      .output_eth_hdr_valid(bOHdrValid), .output_eth_hdr_ready(1'b1),
      .output_eth_dest_mac(bODest), .output_eth_src_mac(bOSrc), .output_eth_type(bOType),
      .output_eth_payload_tdata(bOData), .output_eth_payload_tkeep(bOKeep),
      .output_eth_payload_tvalid(bOValid), .output_eth_payload_tready(1'b1),
      .output_eth_payload_tlast(bOLast), .output_eth_payload_tuser(bOUser),
      .grant_valid(bGrantValid), .grant_index(bGrantIndex)
   );

   // Beat contents encode source, frame and beat number so misrouting is visible.
   function automatic logic [63:0] beatData(int s, int f, int b);
      logic [7:0]  sb;
      logic [7:0]  fb;
      logic [15:0] bb;
      sb = 8'(s);
      fb = 8'(f);
      bb = 16'(b);
      return {sb, fb, bb, 32'h5A5A_0000 + 32'(b)};
   endfunction

   task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(string name);
      tests++;
      failures++;
      $display("[TB] FAIL %s: bound expired before the expected event", name);
   endtask

   task automatic clearModel();
      for (int s = 0; s < 4; s++) begin
         pend[s] = 0; beats[s] = 1; beatIdx[s] = 0; frameNo[s] = 0; hdrSent[s] = 1'b0;
      end
      expBeatQ.delete();
      expHdrQ.delete();
      grantLog.delete();
      outBeats = 0; framesOut = 0;
      expectHdrValid = 1'b0; expectOutValid = 1'b0;
      randReady = 1'b0; hdrReadyCtl = 1'b1;
      hdrValid = '0; pValid = '0; pLast = '0; pUser = '0;
      destMac = '0; srcMac = '0; ethType = '0; pData = '0; pKeep = '0;
      oReady = 1'b1; oHdrReady = 1'b1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      clearModel();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One clock: drive the source models, check outputs on the falling edge,
   // then advance the models using the handshakes seen before the rising edge.
   task automatic applyStimulus();
      logic [3:0] hFire, pFire;
      logic [3:0] savedReady;
      tbBeat_t    actBeat, expBeat;
      for (int s = 0; s < 4; s++) begin
         hdrValid[s] = (pend[s] > 0) && !hdrSent[s];
         destMac[s*48 +: 48] = 48'h0200_0000_0000 | 48'(s);
         srcMac[s*48 +: 48]  = {16'h0A00, 16'(frameNo[s]), 16'(s)};
         ethType[s*16 +: 16] = 16'h0800 + 16'(s);
         pValid[s] = (pend[s] > 0) && (beatIdx[s] < beats[s]);
         pData[s*64 +: 64] = beatData(s, frameNo[s], beatIdx[s]);
         pLast[s] = (beatIdx[s] == beats[s] - 1);
         pKeep[s*8 +: 8] = pLast[s] ? 8'h0F : 8'hFF;
         pUser[s] = ((beatIdx[s] + s) % 2) == 1;
      end
      oReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      oHdrReady = hdrReadyCtl;
      @(negedge clk);
      if (expectHdrValid) checkOutput("hdrLatency", 128'(oHdrValid), 128'(1));
      if (expectOutValid) checkOutput("payloadLatency", 128'(oValid), 128'(1));
      expectHdrValid = 1'b0;
      expectOutValid = 1'b0;
      if (oHdrValid && oHdrReady) begin
         if (expHdrQ.size() == 0) failNow("spuriousHeader");
         else checkOutput("header", 128'({oDest, oSrc, oType}), 128'(expHdrQ.pop_front()));
      end
      if (oValid && oReady) begin
         actBeat = {oData, oKeep, oLast, oUser};
         if (expBeatQ.size() == 0) begin
            failNow("spuriousBeat");
         end else begin
            expBeat = expBeatQ.pop_front();
            checkOutput("beat", 128'(actBeat), 128'(expBeat));
         end
         checkOutput("beatSource", 128'(oData[63:56]), 128'(grantIndex));
         outBeats++;
         if (oLast) framesOut++;
      end
      hFire = hdrValid & hdrReady;
      pFire = pValid & pReady;
      if (pReady != 4'b0000) checkOutput("treadyGranted", 128'(pReady & ~(4'b0001 << grantIndex)), 128'(0));
      for (int s = 0; s < 4; s++) begin
         if (hFire[s]) begin
            checkOutput("gapBeforeGrant", 128'(grantValid), 128'(0));
            grantLog.push_back(s);
            expHdrQ.push_back({destMac[s*48 +: 48], srcMac[s*48 +: 48], ethType[s*16 +: 16]});
            expectHdrValid = 1'b1;
         end
         if (pFire[s]) begin
            expBeatQ.push_back({pData[s*64 +: 64], pKeep[s*8 +: 8], pLast[s], pUser[s]});
            expectOutValid = 1'b1;
         end
      end
      if (randReady) begin
         savedReady = pReady;
         oReady = ~oReady;
         #1;
         checkOutput("treadyRegistered", 128'(pReady), 128'(savedReady));
         oReady = ~oReady;
         #1;
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
         if (hFire[s]) hdrSent[s] = 1'b1;
         if (pFire[s]) beatIdx[s]++;
         if (hdrSent[s] && beatIdx[s] == beats[s]) begin
            pend[s]--; frameNo[s]++; hdrSent[s] = 1'b0; beatIdx[s] = 0;
         end
      end
   endtask

   function automatic bit modelIdle();
      for (int s = 0; s < 4; s++) if (pend[s] != 0) return 1'b0;
      return (expBeatQ.size() == 0) && (expHdrQ.size() == 0) && !grantValid;
   endfunction

   task automatic runUntilIdle(int maxCycles, string name);
      int n;
      n = 0;
      while (!modelIdle() && n < maxCycles) begin
         applyStimulus();
         n++;
      end
      if (!modelIdle()) failNow(name);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int bWins;
      int expOrder[5];
      vecs[0]  = '{4'b0100, 2};  vecs[1]  = '{4'b1111, 3};
      vecs[2]  = '{4'b1111, 0};  vecs[3]  = '{4'b0011, 1};
      vecs[4]  = '{4'b1010, 3};  vecs[5]  = '{4'b0001, 0};
      vecs[6]  = '{4'b1000, 3};  vecs[7]  = '{4'b0110, 1};
      vecs[8]  = '{4'b0110, 2};  vecs[9]  = '{4'b0110, 1};
      vecs[10] = '{4'b1001, 3};  vecs[11] = '{4'b1001, 0};
      expOrder = '{0, 1, 2, 3, 0};
      bHdrValid = '0;
      bPValid = '0;

      doReset();
      checkOutput("resetGrantValid", 128'(grantValid), 128'(0));
      checkOutput("resetGrantIndex", 128'(grantIndex), 128'(0));
      checkOutput("resetHdrValid", 128'(oHdrValid), 128'(0));
      checkOutput("resetOutValid", 128'({oValid, oData, oKeep, oLast, oUser}), 128'(0));
      checkOutput("resetReady", 128'({hdrReady, pReady}), 128'(0));

      pend[2] = 1; beats[2] = 3;
      runUntilIdle(50, "singleSourceTimeout");
      checkOutput("singleGrantCount", 128'(grantLog.size()), 128'(1));
      if (grantLog.size() > 0) checkOutput("singleGrantIndex", 128'(grantLog[0]), 128'(2));
      checkOutput("singleBeats", 128'(outBeats), 128'(3));
      checkOutput("singleFrames", 128'(framesOut), 128'(1));

      doReset();
      for (int s = 0; s < 4; s++) begin pend[s] = 1; beats[s] = 2; end
      pend[0] = 2;
      runUntilIdle(100, "allSourcesTimeout");
      checkOutput("rrGrantCount", 128'(grantLog.size()), 128'(5));
      for (int i = 0; i < 5 && i < grantLog.size(); i++) begin
         checkOutput("rrGrantOrder", 128'(grantLog[i]), 128'(expOrder[i]));
      end

      doReset();
      for (int i = 0; i < 12; i++) begin
         grantLog.delete();
         for (int s = 0; s < 4; s++) begin
            if (vecs[i].reqMask[s]) begin pend[s] = 1; beats[s] = 1; end
         end
         n = 0;
         while (grantLog.size() == 0 && n < 10) begin applyStimulus(); n++; end
         for (int s = 0; s < 4; s++) if (!hdrSent[s] && beatIdx[s] == 0) pend[s] = 0;
         runUntilIdle(30, "vectorTimeout");
         if (grantLog.size() == 0) failNow("vectorNoGrant");
         else checkOutput("vectorGrant", 128'(grantLog[0]), 128'(vecs[i].expGrant));
      end

      outBeats = 0;
      randReady = 1'b1;
      pend[1] = 1; beats[1] = 8;
      runUntilIdle(300, "randomReadyTimeout");
      randReady = 1'b0;
      checkOutput("randomReadyBeats", 128'(outBeats), 128'(8));

      framesOut = 0;
      hdrReadyCtl = 1'b0;
      pend[3] = 1; beats[3] = 2;
      n = 0;
      while (framesOut == 0 && n < 30) begin applyStimulus(); n++; end
      if (framesOut == 0) failNow("holdTlastTimeout");
      repeat (3) applyStimulus();
      checkOutput("holdActive", 128'(grantValid), 128'(1));
      checkOutput("holdHdrValid", 128'(oHdrValid), 128'(1));
      hdrReadyCtl = 1'b1;
      applyStimulus();
      checkOutput("releaseIdle", 128'(grantValid), 128'(0));
      runUntilIdle(20, "holdDrainTimeout");

      bHdrValid = 4'b1010;
      bPValid = 4'b1010;
      bWins = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bHdrReady != 4'b0000) begin
            checkOutput("fixedWinner", 128'(bHdrReady), 128'(4'b0010));
            bWins++;
         end
      end
      checkOutput("fixedGrantCount", 128'(bWins >= 3), 128'(1));
      @(posedge clk);
      #1;
      bHdrValid = '0;
      bPValid = '0;

      doReset();
      pend[1] = 1; beats[1] = 4;
      n = 0;
      while (outBeats < 2 && n < 30) begin applyStimulus(); n++; end
      if (outBeats < 2) failNow("midResetTimeout");
      rst = 1'b1;
      #1;
      checkOutput("midResetGrant", 128'({grantValid, grantIndex}), 128'(0));
      checkOutput("midResetHdr", 128'({oHdrValid, oDest, oSrc, oType}), 128'(0));
      checkOutput("midResetPayload", 128'({oValid, oData, oKeep, oLast, oUser}), 128'(0));
      checkOutput("midResetReady", 128'(pReady), 128'(0));
      clearModel();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int s = 0; s < 4; s++) begin pend[s] = 1; beats[s] = 1; end
      n = 0;
      while (grantLog.size() == 0 && n < 10) begin applyStimulus(); n++; end
      if (grantLog.size() == 0) failNow("postResetNoGrant");
      else checkOutput("postResetFirstGrant", 128'(grantLog[0]), 128'(0));
      runUntilIdle(60, "postResetDrainTimeout");

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/eth_tx_arb_64.md
# eth_tx_arb_64

Frame-atomic round-robin arbiter that shares one `eth_axis_tx_64` transmit path, and behind it the 10G MAC TX FIFO, among `S_COUNT` Ethernet-frame sources. Each source presents a header handshake (dest/src MAC, ethertype) plus a 64-bit payload stream. The arbiter grants one source per frame, forwards its header through a register and its payload through a registered skid stage, and releases the grant only after the payload `tlast` beat has been accepted. It sits between application logic and `eth_axis_tx_64`, in the same `clk` domain.

## Interface
- `S_COUNT`, 4: number of sources, 2..16.
- `ARB_RR`, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.

- `clk` in 1: 156.25 MHz core clock.
- `rst` in 1: reset, asynchronous and active-high.
- `input_eth_hdr_valid` / `input_eth_hdr_ready` in/out S_COUNT: per-source header handshake.
- `input_eth_dest_mac`, `input_eth_src_mac` in S_COUNT*48: flattened MACs; source i in bits [i*48 +: 48].
- `input_eth_type` in S_COUNT*16: flattened ethertype.
- `input_eth_payload_tdata` in S_COUNT*64; `_tkeep` in S_COUNT*8; `_tvalid`, `_tlast`, `_tuser` in S_COUNT; `_tready` out S_COUNT.
- `output_eth_hdr_valid` out 1; `output_eth_hdr_ready` in 1; `output_eth_dest_mac`, `output_eth_src_mac` out 48; `output_eth_type` out 16.
- `output_eth_payload_tdata` out 64; `_tkeep` out 8; `_tvalid`, `_tlast`, `_tuser` out 1; `_tready` in 1.
- `grant_valid` out 1: a frame is in progress.
- `grant_index` out clog2(S_COUNT): index of the granted source.

## Operation
- States: IDLE, ACTIVE.
- IDLE:
  - If any `input_eth_hdr_valid` is set, the winner w is chosen combinationally. In RR mode, the search starts at `last+1` mod S_COUNT. In fixed mode, the lowest index wins.
  - In that same cycle `input_eth_hdr_ready[w]`=1: the header is latched into the output registers, `output_eth_hdr_valid`←1, `grant_index`←w, `grant_valid`←1, `last`←w, and the state goes to ACTIVE.
- ACTIVE:
  - `input_eth_hdr_ready` is all 0.
  - `output_eth_hdr_valid` clears on the cycle `output_eth_hdr_ready` is high.
  - Payload of source w passes through the skid stage; `input_eth_payload_tready[w]` = skid not full; all other sources' payload tready = 0.
  - When the `tlast` beat of w is accepted into the skid stage, input tready drops for the rest of the frame.
  - Return to IDLE once that `tlast` beat has left the output (`tvalid & tready & tlast`) and `output_eth_hdr_valid`=0.
- Non-granted sources are fully stalled; their valids are ignored except for arbitration in IDLE.
- `tuser` passes through unchanged per beat; the arbiter never drops or truncates a frame.
- Zero-payload frames are not supported: every frame has ≥1 payload beat with `tlast`.

## Timing
- Reset (async, immediate):
  - state=IDLE, `last`=S_COUNT-1, so source 0 is first after reset.
  - All output valids, `grant_valid`, `grant_index`, header and data registers = 0.
  - Skid stage empty.
- Header latency: 1 cycle from input header accept to `output_eth_hdr_valid`.
- Payload latency: 1 cycle input→output.
- Full throughput (1 beat/clk) while `output_eth_payload_tready`=1.
- Skid stage is 2 entries. Input tready is registered, i.e. it is a function of the occupancy register only, never of `output_eth_payload_tready`.
- Inter-frame gap:
  - Next header accept occurs the cycle after the return to IDLE, i.e. ≥1 idle cycle between grants.
  - Payload beats of the new frame may overlap the previous frame's header completion only within the same grant.
- Simultaneous events:
  - `tlast` exit and header accept in the same cycle → IDLE next cycle.
  - A request arriving the same cycle the arbiter returns to IDLE is considered in the next cycle.
- Wrap-around: with `last`=S_COUNT-1, the search starts at 0.
- Reset mid-frame clears everything. No `tlast` is emitted, so downstream must share the same `rst`.

## Structure
- Shared package/include `eth_arb_defs`: state encodings, `ETH_HDR_W`=112, `DATA_W`=64, `KEEP_W`=8.
- Sub-module `rr_prio_enc`: parameterised N-wide round-robin priority encoder. Inputs are request vector and `last`; outputs are `valid` and `index`. Fixed mode uses the same encoder with start position 0.
- Skid stage is inline: two data registers plus an occupancy counter.

## Test plan
- Reset: only source 2 requests, header dest=02:00:00:00:00:02, 3-beat payload → `grant_index`=2; header out 1 cycle after accept; 3 beats out in order, `tlast` on beat 3; back to IDLE.
- All 4 sources request continuously, 2 beats each → grants in order 0,1,2,3,0; no beat interleaving between frames; `grant_valid` low ≥1 cycle between frames.
- `output_eth_payload_tready` toggled randomly (50%) during an 8-beat frame → all 8 beats delivered exactly once, in order, with tkeep/tuser intact; input tready never depends combinationally on output ready.
- `output_eth_hdr_ready` held low until after `tlast` leaves the output → state stays ACTIVE until header accept, then IDLE the next cycle.
- Fixed-priority build (`ARB_RR`=0): sources 1 and 3 request repeatedly → source 1 wins every arbitration.
- Assert `rst` on beat 2 of a 4-beat frame → all outputs 0 immediately; after release, `grant_index` restarts from source 0 priority.
